// File: rtl/playback_control_fsm.sv
// Keyboard command decoder, restart handshake sequencer and sample-strobe divider for the flash audio reader.
// Outputs are registered and update one clk_in cycle after the command or ack that causes them.
// Optional macro RESTART_PAUSE_EN: when defined, a completed restart also stops playback until 'E'.
module playback_control_fsm #(
  parameter int DIV_W       = 16,
  parameter int DIV_DEFAULT = 2273,
  parameter int DIV_STEP    = 64,
  parameter int DIV_MIN     = 256,
  parameter int DIV_MAX     = 65535
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic [7:0]       kbd_char,
  input  logic             kbd_valid,
  input  logic             speed_up,
  input  logic             speed_down,
  input  logic             speed_reset,
  input  logic             restart_ack,
  output logic             play_enable,
  output logic             direction,
  output logic             restart,
  output logic             sample_strobe,
  output logic [DIV_W-1:0] divisor
);

  typedef enum logic [1:0] {
    CMD      = 2'd0,
    WAIT_ACK = 2'd1,
    RELEASE  = 2'd2
  } state_t;

  // Divisor arithmetic runs one bit wider so neither bound can wrap.
  localparam logic [DIV_W:0]   LP_MIN  = (DIV_W+1)'(DIV_MIN);
  localparam logic [DIV_W:0]   LP_MAX  = (DIV_W+1)'(DIV_MAX);
  localparam logic [DIV_W:0]   LP_STEP = (DIV_W+1)'(DIV_STEP);
  localparam logic [DIV_W-1:0] LP_DEF  = DIV_W'(DIV_DEFAULT);
  localparam logic [DIV_W-1:0] LP_ONE  = DIV_W'(1);

  state_t           r_state;
  logic             r_play;
  logic             r_dir;
  logic             r_restart;
  logic             r_strobe;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_cnt;

  logic [7:0]       w_lc;
  logic             w_key_e;
  logic             w_key_d;
  logic             w_key_f;
  logic             w_key_b;
  logic             w_key_r;
  logic [DIV_W:0]   w_div_wide;
  logic [DIV_W:0]   w_div_dec;
  logic [DIV_W:0]   w_div_inc;
  logic [DIV_W-1:0] w_div_nxt;

  // Setting bit 5 folds upper-case letters onto lower-case for case-insensitive decode.
  assign w_lc    = kbd_char | 8'h20;
  assign w_key_e = kbd_valid && (w_lc == 8'h65);
  assign w_key_d = kbd_valid && (w_lc == 8'h64);
  assign w_key_f = kbd_valid && (w_lc == 8'h66);
  assign w_key_b = kbd_valid && (w_lc == 8'h62);
  assign w_key_r = kbd_valid && (w_lc == 8'h72);

  assign w_div_wide = {1'b0, r_div};
  assign w_div_dec  = w_div_wide - LP_STEP;
  assign w_div_inc  = w_div_wide + LP_STEP;

  // Next divisor: reset beats everything, simultaneous up/down cancel, then saturating step.
  always_comb begin
    w_div_nxt = r_div;
    if (speed_reset) begin
      w_div_nxt = LP_DEF;
    end else if (speed_up && speed_down) begin
      w_div_nxt = r_div;
    end else if (speed_up) begin
      w_div_nxt = (w_div_wide >= LP_MIN + LP_STEP) ? w_div_dec[DIV_W-1:0] : LP_MIN[DIV_W-1:0];
    end else if (speed_down) begin
      w_div_nxt = (w_div_inc > LP_MAX) ? LP_MAX[DIV_W-1:0] : w_div_inc[DIV_W-1:0];
    end
  end

  // Command decode and restart handshake; later assignments intentionally override earlier ones.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_state   <= CMD;
      r_play    <= 1'b0;
      r_dir     <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      if (w_key_e) r_play <= 1'b1;
      if (w_key_d) r_play <= 1'b0;
      if (w_key_f) r_dir  <= 1'b0;
      if (w_key_b) r_dir  <= 1'b1;
      case (r_state)
        CMD: begin
          if (w_key_r) begin
            r_restart <= 1'b1;
            r_state   <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          // No timeout: the reader always answers eventually.
          if (restart_ack) begin
            r_restart <= 1'b0;
            r_state   <= RELEASE;
`ifdef RESTART_PAUSE_EN
            r_play    <= 1'b0;
`endif
          end
        end
        RELEASE: begin
          if (!restart_ack) r_state <= CMD;
        end
        default: r_state <= CMD;
      endcase
    end
  end

  // Strobe divider and divisor register; a new divisor is only picked up on the next reload.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      r_div    <= LP_DEF;
      r_cnt    <= LP_DEF - LP_ONE;
      r_strobe <= 1'b0;
    end else begin
      r_div <= w_div_nxt;
      if (r_cnt == '0) begin
        r_strobe <= 1'b1;
        r_cnt    <= r_div - LP_ONE;
      end else begin
        r_strobe <= 1'b0;
        r_cnt    <= r_cnt - LP_ONE;
      end
    end
  end

  assign play_enable   = r_play;
  assign direction     = r_dir;
  assign restart       = r_restart;
  assign sample_strobe = r_strobe;
  assign divisor       = r_div;

endmodule

// File: tb/tb_playback_control_fsm.sv
// Randomised and directed bench for playback_control_fsm against a cycle-level behavioural model.
module tb_playback_control_fsm;

  localparam int DIV_W   = 16;
  localparam int DEF     = 10;
  localparam int STEP    = 64;
  localparam int DMIN    = 256;
  localparam int DMAX    = 600;

  logic             clk_in = 1'b0;
  logic             reset = 1'b1;
  logic [7:0]       kbd_char = 8'h00;
  logic             kbd_valid = 1'b0;
  logic             speed_up = 1'b0;
  logic             speed_down = 1'b0;
  logic             speed_reset = 1'b0;
  logic             restart_ack = 1'b0;
  logic             play_enable;
  logic             direction;
  logic             restart;
  logic             sample_strobe;
  logic [DIV_W-1:0] divisor;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: absolute cycle count and cycle of the next expected strobe.
  int   m_cyc, m_next, m_div, m_phase;
  logic m_play, m_dir, m_req, m_strobe;

  playback_control_fsm #(
    .DIV_W(DIV_W), .DIV_DEFAULT(DEF), .DIV_STEP(STEP), .DIV_MIN(DMIN), .DIV_MAX(DMAX)
  ) dut (
    .clk_in(clk_in), .reset(reset), .kbd_char(kbd_char), .kbd_valid(kbd_valid),
    .speed_up(speed_up), .speed_down(speed_down), .speed_reset(speed_reset),
    .restart_ack(restart_ack), .play_enable(play_enable), .direction(direction),
    .restart(restart), .sample_strobe(sample_strobe), .divisor(divisor)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: strobes every divisor cycles, saturating speed steps, restart handshake phases.
  always @(posedge clk_in or posedge reset) begin : mdl
    int cyc, nd;
    logic pl;
    logic [7:0] k;
    if (reset) begin
      m_cyc <= 0; m_next <= DEF; m_div <= DEF; m_phase <= 0;
      m_play <= 1'b0; m_dir <= 1'b0; m_req <= 1'b0; m_strobe <= 1'b0;
    end else begin
      cyc = m_cyc + 1;
      m_cyc <= cyc;
      if (cyc == m_next) begin
        m_strobe <= 1'b1;
        m_next   <= cyc + m_div;
      end else begin
        m_strobe <= 1'b0;
      end
      nd = m_div;
      if (speed_reset) nd = DEF;
      else if (speed_up && speed_down) nd = m_div;
      else if (speed_up) nd = (m_div - STEP < DMIN) ? DMIN : m_div - STEP;
      else if (speed_down) nd = (m_div + STEP > DMAX) ? DMAX : m_div + STEP;
      m_div <= nd;
      k  = kbd_char | 8'h20;
      pl = m_play;
      if (kbd_valid) begin
        if (k == 8'h65) pl = 1'b1;
        if (k == 8'h64) pl = 1'b0;
        if (k == 8'h66) m_dir <= 1'b0;
        if (k == 8'h62) m_dir <= 1'b1;
      end
      if (m_phase == 0) begin
        if (kbd_valid && k == 8'h72) begin m_req <= 1'b1; m_phase <= 1; end
      end else if (m_phase == 1) begin
        if (restart_ack) begin
          m_req <= 1'b0; m_phase <= 2;
`ifdef RESTART_PAUSE_EN
          pl = 1'b0;
`endif
        end
      end else if (!restart_ack) begin
        m_phase <= 0;
      end
      m_play <= pl;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge clk_in) begin
    #1;
    chk("play_enable", play_enable, m_play);
    chk("direction", direction, m_dir);
    chk("restart", restart, m_req);
    chk("sample_strobe", sample_strobe, m_strobe);
    chk("divisor", divisor, m_div);
  end

  task automatic key(input logic [7:0] c);
    @(posedge clk_in); #2;
    kbd_char = c; kbd_valid = 1'b1;
    @(posedge clk_in); #2;
    kbd_valid = 1'b0;
  endtask

  task automatic spd(input logic u, input logic d, input logic r);
    @(posedge clk_in); #2;
    speed_up = u; speed_down = d; speed_reset = r;
    @(posedge clk_in); #2;
    speed_up = 1'b0; speed_down = 1'b0; speed_reset = 1'b0;
  endtask

  task automatic strobe_gap(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk_in); #1;
      if (sample_strobe) begin n = i; break; end
    end
  endtask

  logic [7:0] keys [12];
  int gap;

  initial begin
    keys = '{8'h45, 8'h65, 8'h44, 8'h64, 8'h46, 8'h66, 8'h42, 8'h62, 8'h52, 8'h72, 8'h41, 8'h00};
    repeat (3) @(posedge clk_in);
    #2;
    chk("reset_divisor", divisor, 10);
    chk("reset_play", play_enable, 0);
    reset = 1'b0;
    strobe_gap(gap);
    chk("first_strobe_cycle", gap, 10);
    strobe_gap(gap);
    chk("strobe_period", gap, 10);

    key(8'h65); chk("key_e_play", play_enable, 1);
    key(8'h62); chk("key_b_dir", direction, 1);
    key(8'h41); chk("key_a_play", play_enable, 1);
    chk("key_a_dir", direction, 1);

    key(8'h52); chk("restart_set", restart, 1);
    repeat (20) @(posedge clk_in);
    #2; chk("restart_held", restart, 1);
    restart_ack = 1'b1;
    @(posedge clk_in); #2;
    chk("restart_clear", restart, 0);
`ifdef RESTART_PAUSE_EN
    chk("restart_pause_play", play_enable, 0);
`else
    chk("restart_keep_play", play_enable, 1);
`endif
    kbd_char = 8'h52; kbd_valid = 1'b1;
    @(posedge clk_in); #2;
    kbd_valid = 1'b0; restart_ack = 1'b0;
    repeat (3) @(posedge clk_in);
    #2; chk("restart_dropped", restart, 0);

    spd(1, 1, 1); chk("spd_prio_reset", divisor, 10);
    spd(1, 0, 0); chk("spd_up_min", divisor, 256);
    spd(1, 0, 0); chk("spd_up_sat", divisor, 256);
    spd(0, 1, 0); chk("spd_down", divisor, 320);
    spd(1, 1, 0); chk("spd_both", divisor, 320);
    repeat (5) spd(0, 1, 0);
    chk("spd_down_sat", divisor, 600);

    spd(0, 0, 1); spd(1, 0, 0);
    repeat (4) spd(0, 1, 0);
    chk("div_512", divisor, 512);
    key(8'h45); key(8'h72);
    repeat (3) @(posedge clk_in);
    #2; reset = 1'b1;
    #1;
    chk("arst_play", play_enable, 0);
    chk("arst_dir", direction, 0);
    chk("arst_restart", restart, 0);
    chk("arst_strobe", sample_strobe, 0);
    chk("arst_divisor", divisor, 10);
    @(posedge clk_in); #2; reset = 1'b0;
    strobe_gap(gap);
    chk("post_reset_strobe", gap, 10);
    key(8'h72); chk("post_reset_restart", restart, 1);
    restart_ack = 1'b1;
    @(posedge clk_in); #2; restart_ack = 1'b0;

    for (int c = 0; c < 5000; c++) begin
      @(posedge clk_in); #2;
      reset       = ($urandom_range(0, 799) == 0);
      kbd_valid   = ($urandom_range(0, 3) == 0);
      kbd_char    = keys[$urandom_range(0, 11)];
      if ($urandom_range(0, 9) == 0) kbd_char = 8'($urandom);
      speed_up    = ($urandom_range(0, 30) == 0);
      speed_down  = ($urandom_range(0, 25) == 0);
      speed_reset = ($urandom_range(0, 300) == 0);
      if ($urandom_range(0, 7) == 0) restart_ack = ~restart_ack;
    end
    @(posedge clk_in); #2;
    reset = 1'b0; kbd_valid = 1'b0; speed_up = 1'b0; speed_down = 1'b0; speed_reset = 1'b0;
    repeat (5) @(posedge clk_in);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
